// File: rtl/sarm_mem_pkg.sv
// Shared types and constants for the SARM MEM-stage SRAM path.
package sarm_mem_pkg;

  localparam int unsigned SRAM_HALF_W    = 16;
  localparam int unsigned SRAM_CNT_W     = 4;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_addr_map.sv
// Byte address to SRAM word index: (address - BASE_ADDR) >> 2, modular, truncated.
module sram_addr_map
  import sarm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
  parameter int unsigned IDX_W     = 17
) (
  input  logic [31:0]      address_i,
  output logic [IDX_W-1:0] word_idx_o
);

  assign word_idx_o = IDX_W'((address_i - BASE_ADDR) >> 2);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller: each 32-bit load/store becomes two 16-bit async SRAM accesses.
// Optional SRAM_PERF_CNT_EN adds a stall_cycles counter of cycles with ready=0.
module sram_controller
  import sarm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR,
  parameter int unsigned SRAM_AW    = 18,
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read_en,
  input  logic                   write_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_AW-1:0]     sram_addr,
  input  logic [SRAM_HALF_W-1:0] sram_dq_in,
  output logic [SRAM_HALF_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
`ifdef SRAM_PERF_CNT_EN
  , output logic [31:0]          stall_cycles
`endif
);

  localparam int unsigned IDX_W = SRAM_AW - 1;
  localparam logic [SRAM_CNT_W-1:0] LAST_CNT = SRAM_CNT_W'(ACC_CYCLES - 1);

  sram_state_t             state_q;
  logic [SRAM_CNT_W-1:0]   cnt_q;
  logic                    is_wr_q;
  logic [IDX_W-1:0]        idx_q;
  logic [SRAM_HALF_W-1:0]  hi_data_q;
  logic [31:0]             read_data_q;
  logic [SRAM_AW-1:0]      sram_addr_q;
  logic [SRAM_HALF_W-1:0]  dq_out_q;
  logic                    dq_oe_q;
  logic                    we_n_q;
  logic                    oe_n_q;

  logic [IDX_W-1:0]        word_idx;
  logic                    req;
  logic                    phase_last;

  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_addr_map (
    .address_i  (address),
    .word_idx_o (word_idx)
  );

  assign req        = read_en | write_en;
  assign phase_last = (cnt_q == LAST_CNT);
  assign ready      = (state_q == DONE) || ((state_q == IDLE) && !req);

  // Pins are loaded one edge ahead so each phase presents stable registered values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      hi_data_q   <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q     <= LOW;
            cnt_q       <= '0;
            is_wr_q     <= write_en;
            idx_q       <= word_idx;
            hi_data_q   <= write_data[2*SRAM_HALF_W-1:SRAM_HALF_W];
            sram_addr_q <= {word_idx, 1'b0};
            if (write_en) begin
              dq_out_q <= write_data[SRAM_HALF_W-1:0];
              dq_oe_q  <= 1'b1;
              we_n_q   <= 1'b0;
            end else begin
              oe_n_q   <= 1'b0;
            end
          end
        end
        LOW: begin
          if (phase_last) begin
            state_q     <= HIGH;
            cnt_q       <= '0;
            sram_addr_q <= {idx_q, 1'b1};
            if (is_wr_q) begin
              dq_out_q <= hi_data_q;
            end else begin
              read_data_q[SRAM_HALF_W-1:0] <= sram_dq_in;
            end
          end else begin
            cnt_q <= cnt_q + SRAM_CNT_W'(1);
          end
        end
        HIGH: begin
          if (phase_last) begin
            state_q <= DONE;
            cnt_q   <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            if (!is_wr_q) begin
              read_data_q[2*SRAM_HALF_W-1:SRAM_HALF_W] <= sram_dq_in;
            end
          end else begin
            cnt_q <= cnt_q + SRAM_CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] stall_q;

  // Free-running stall counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, SRAM model, read_data scoreboard.
module tb_sram_controller;

  localparam int unsigned ACC = 2;
  localparam int unsigned AW  = 18;
  localparam int unsigned LAT = 1 + 2 * ACC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_en = 1'b0;
  logic          write_en = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_in;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;
`ifdef SRAM_PERF_CNT_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   s0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem [logic [AW-1:0]];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR  (32'd1024),
    .SRAM_AW    (AW),
    .ACC_CYCLES (ACC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_en     (read_en),
    .write_en    (write_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
`ifdef SRAM_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hA5A5;
  endfunction

  function automatic logic [AW-2:0] idx_of(input logic [31:0] a);
    return (AW-1)'((a - 32'd1024) >> 2);
  endfunction

  // Async SRAM model: write while strobed, read data follows address when enabled.
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
  end
  always @(sram_addr or sram_oe_n) begin
    sram_dq_in = sram_oe_n ? 16'h0 : mem_rd(sram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    int              stall;
    int              pin_err;
    bit              phase_hi;
    logic [AW-2:0]   idx;
    logic [AW-1:0]   pa;
    logic [15:0]     pd;
    idx = idx_of(a);
    exp_q.push_back(exp_rd);
    @(negedge clk);
    read_en = rd; write_en = wr; address = a; write_data = d;
    stall = 0; pin_err = 0;
    #1;
    while (!ready && stall < 64) begin
      stall++;
      if (!sram_we_n && !sram_oe_n) pin_err++;
      if (stall == 1) begin
        if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) pin_err++;
      end else begin
        phase_hi = (stall > 1 + ACC);
        pa = {idx, phase_hi};
        pd = phase_hi ? d[31:16] : d[15:0];
        if (sram_addr !== pa) pin_err++;
        if (wr) begin
          if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1 ||
              sram_dq_out !== pd) pin_err++;
        end else if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
          pin_err++;
        end
      end
      @(negedge clk); #1;
    end
    check({tag, " latency"}, 32'(stall), 32'(LAT));
    check({tag, " done_pins"}, 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'h6);
    check({tag, " phase_pins"}, 32'(pin_err), 32'h0);
    check({tag, " read_data"}, read_data, exp_q.pop_front());
    if (wr) begin
      check({tag, " mem_lo"}, 32'(mem_rd({idx, 1'b0})), 32'(d[15:0]));
      check({tag, " mem_hi"}, 32'(mem_rd({idx, 1'b1})), 32'(d[31:16]));
    end
  endtask

  initial begin
    vecs[0] = '{rd: 0, wr: 1, addr: 32'd1028, data: 32'hDEADBEEF, exp_rd: 32'h00000000};
    vecs[1] = '{rd: 1, wr: 0, addr: 32'd1028, data: 32'h0,        exp_rd: 32'hDEADBEEF};
    vecs[2] = '{rd: 0, wr: 1, addr: 32'd1024, data: 32'hCAFEF00D, exp_rd: 32'hDEADBEEF};
    vecs[3] = '{rd: 1, wr: 0, addr: 32'd1024, data: 32'h0,        exp_rd: 32'hCAFEF00D};
    vecs[4] = '{rd: 1, wr: 1, addr: 32'd1032, data: 32'h12345678, exp_rd: 32'hCAFEF00D};
    vecs[5] = '{rd: 1, wr: 0, addr: 32'd1032, data: 32'h0,        exp_rd: 32'h12345678};
    vecs[6] = '{rd: 0, wr: 1, addr: 32'd1020, data: 32'h0BADC0DE, exp_rd: 32'h12345678};
    vecs[7] = '{rd: 1, wr: 0, addr: 32'd1020, data: 32'h0,        exp_rd: 32'h0BADC0DE};
    vecs[8] = '{rd: 1, wr: 0, addr: 32'd1027, data: 32'h0,        exp_rd: 32'hCAFEF00D};
    vecs[9] = '{rd: 1, wr: 0, addr: 32'd2048, data: 32'h0,        exp_rd: 32'hA5A5A5A5};

    #1 rst = 1'b0;
    #2;
    check("reset read_data", read_data, 32'h0);
    check("reset pins", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'h6);
    check("reset sram_addr", 32'(sram_addr), 32'h0);
    check("reset dq_out", 32'(sram_dq_out), 32'h0);
    check("reset ready", 32'(ready), 32'h1);
`ifdef SRAM_PERF_CNT_EN
    check("reset stall_cycles", stall_cycles, 32'h0);
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("idle ready", 32'(ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
             $sformatf("vec%0d", i));
    end

    // Back-to-back store then load of the same word.
    access(1'b0, 1'b1, 32'd1024, 32'h600DF00D, 32'hA5A5A5A5, "b2b_store");
    access(1'b1, 1'b0, 32'd1024, 32'h0, 32'h600DF00D, "b2b_load");

    @(negedge clk); read_en = 1'b0; write_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle hold ready", 32'(ready), 32'h1);
    check("idle hold read_data", read_data, 32'h600DF00D);

`ifdef SRAM_PERF_CNT_EN
    s0 = stall_cycles;
    access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, "perf_ld0");
    access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, "perf_ld1");
    access(1'b1, 1'b0, 32'd1020, 32'h0, 32'h0BADC0DE, "perf_ld2");
    @(negedge clk); read_en = 1'b0; write_en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("perf stall_cycles", stall_cycles - s0, 32'd15);
`endif

    // Reset asserted in the middle of a store aborts it immediately.
    @(negedge clk);
    write_en = 1'b1; address = 32'd1028; write_data = 32'h11112222;
    @(negedge clk); #1;
    check("midwrite we_n low", 32'(sram_we_n), 32'h0);
    rst = 1'b0;
    #1;
    check("midwrite rst pins", 32'({sram_we_n, sram_oe_n, sram_dq_oe}), 32'h6);
    check("midwrite rst read_data", read_data, 32'h0);
    check("midwrite rst sram_addr", 32'(sram_addr), 32'h0);
    @(negedge clk);
    write_en = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    check("post reset ready", 32'(ready), 32'h1);
    check("post reset we_n", 32'(sram_we_n), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Replaces the single-cycle data memory in the MEM stage of the SARM pipeline. Consumes the EXE stage register outputs: MEM_R_EN, MEM_W_EN, ALU_result (used as the address) and ST_val. Performs each 32-bit load/store as two 16-bit accesses on an external asynchronous SRAM. Deasserts ready while busy so the top level can freeze every pipeline register until the access completes.

Parameters:
BASE_ADDR, 1024, byte address that maps to SRAM word 0.
SRAM_AW, 18, SRAM address width (16-bit halfword granularity).
ACC_CYCLES, 2, cycles each halfword phase is held on the SRAM pins (range 1..15).

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous, active-low reset
read_en  input  1  load request (EXE_Reg MEM_R_EN)
write_en  input  1  store request (EXE_Reg MEM_W_EN)
address  input  32  byte address (EXE_Reg ALU_result)
write_data  input  32  store value (EXE_Reg ST_val)
read_data  output  32  last completed load value, to MEM_Stage_Reg
ready  output  1  1 = no access pending or access completing this cycle; top level uses ~ready as freeze
sram_addr  output  SRAM_AW  SRAM halfword address
sram_dq_in  input  16  SRAM data bus, read direction
sram_dq_out  output  16  SRAM data bus, write direction
sram_dq_oe  output  1  1 = controller drives the bus (top-level tristate)
sram_we_n  output  1  SRAM write strobe, active low
sram_oe_n  output  1  SRAM output enable, active low

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; read_data=0; sram_addr=0; sram_dq_out=0; sram_dq_oe=0; sram_we_n=1; sram_oe_n=1; phase counter=0. Reset during an access aborts it; no partial write is retried.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - No request: stay in IDLE, ready=1.
  - Request (read_en|write_en): ready=0. Latch the operation, word index and write_data. Next state LOW.
- Word index: (address - BASE_ADDR) >> 2, using 32-bit modular subtraction, truncated to SRAM_AW-1 bits. Address bits [1:0] are ignored.
- LOW: held for ACC_CYCLES cycles; ready=0.
  - sram_addr = {word_idx, 1'b0}.
  - Write: sram_dq_out = data[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read: sram_oe_n=0, and read_data[15:0] is captured from sram_dq_in on the last cycle of the phase.
- HIGH: same as LOW with sram_addr = {word_idx, 1'b1}; uses data[31:16] and captures read_data[31:16].
- DONE: one cycle; ready=1; strobes and drive released (we_n=1, oe_n=1, dq_oe=0). Next state IDLE. The pipeline advances on this edge, so the request inputs are re-sampled fresh in IDLE.
- Latency: ready=0 for 1+2*ACC_CYCLES cycles from the first IDLE cycle with a request; ready=1 in the following DONE cycle.
- Back-to-back requests: IDLE→LOW with no idle bubble other than DONE.
- read_en and write_en both high: treated as a write.
- All SRAM pins are registered, with no combinational path from the request inputs to the pins.
- read_data holds its value across writes and idle cycles; it changes only on load capture or reset.
- ready is combinational from state and the request inputs.

Optional Feature:
SRAM_PERF_CNT_EN.
- Defined: adds output stall_cycles (32 bits) that counts every cycle with ready=0. It is cleared by reset, wraps at 2^32, and never saturates.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sarm_mem_pkg holds:
  - the sram_state_t enum (IDLE, LOW, HIGH, DONE);
  - SRAM_HALF_W=16 and the default BASE_ADDR constant.
- One natural sub-module, sram_addr_map: the combinational byte-address to word-index mapper, reused by future cache logic.
- Phase counter and FSM stay in sram_controller.

Test Plan:
- Reset: rst=0 mid-write (state LOW) → next cycle sram_we_n=1, sram_dq_oe=0, ready=1 with no request, read_data=0.
- Store: address=1028, write_data=0xDEADBEEF, ACC_CYCLES=2 → sram_addr=2 with dq_out=0xBEEF and we_n=0 for 2 cycles; then sram_addr=3 with 0xDEAD for 2 cycles; ready=0 for exactly 5 cycles, then 1.
- Load after store: read_en, address=1028; SRAM model returns stored halfwords → read_data=0xDEADBEEF in the DONE cycle; sram_oe_n=0 only during LOW/HIGH.
- Back-to-back: store to 1024 immediately followed by load from 1024 → second access starts the cycle after DONE; loaded value equals stored value; no overlap of we_n=0 and oe_n=0.
- Simultaneous read_en=write_en=1, address=1032, data=0x12345678 → write performed (SRAM addr 4/5 = 0x5678/0x1234); read_data unchanged.
- With SRAM_PERF_CNT_EN: three loads (ACC_CYCLES=2) → stall_cycles=15; idle cycles do not increment it.
